// File: rtl/bsg_gateway_dcm_prog.sv
// Run-time DCM_CLKGEN reprogrammer: shifts LoadD, LoadM and GO onto PROGEN/PROGDATA,
// then waits for PROGDONE and lock, reporting done or a coded error.
module bsg_gateway_dcm_prog #(
   parameter int unsigned timeout_p   = 4096,
   parameter int unsigned lock_sync_p = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       v_i,
   input  logic [7:0] m_i,
   input  logic [7:0] d_i,
   output logic       ready_o,
   output logic       prog_en_o,
   output logic       prog_data_o,
   input  logic       prog_done_i,
   input  logic       dcm_locked_i,
   output logic       done_o,
   output logic       err_o,
   output logic [1:0] err_code_o
);

   localparam int unsigned CntW = $clog2(timeout_p + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(timeout_p - 1);

   typedef enum logic [3:0] {
      StIdle, StLoadDCmd, StLoadDData, StGap1, StLoadMCmd,
      StLoadMData, StGap2, StGo, StWaitDone, StWaitLock
   } state_e;

   state_e                 state_q, state_d;
   logic [2:0]             bit_q, bit_d;
   logic [15:0]            shift_q, shift_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   seen_low_q, seen_low_d;
   logic                   ill_q, ill_d;
   logic [1:0]             err_code_q, err_code_d;
   logic [lock_sync_p-1:0] sync_q;
   logic                   lock_s;
   logic                   err_now;

   assign lock_s     = sync_q[lock_sync_p-1];
   assign ready_o    = (state_q == StIdle);
   assign err_o      = ill_q | err_now;
   // Timeout errors report their code in the same cycle as the pulse.
   assign err_code_o = err_now ? err_code_d : err_code_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         bit_q      <= '0;
         shift_q    <= '0;
         cnt_q      <= '0;
         seen_low_q <= 1'b0;
         ill_q      <= 1'b0;
         err_code_q <= 2'd0;
         sync_q     <= '0;
      end else begin
         state_q    <= state_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         seen_low_q <= seen_low_d;
         ill_q      <= ill_d;
         err_code_q <= err_code_d;
         sync_q     <= {sync_q[lock_sync_p-2:0], dcm_locked_i};
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q + 3'd1;
      shift_d     = shift_q;
      cnt_d       = '0;
      seen_low_d  = 1'b0;
      ill_d       = 1'b0;
      err_code_d  = err_code_q;
      prog_en_o   = 1'b0;
      prog_data_o = 1'b0;
      done_o      = 1'b0;
      err_now     = 1'b0;
      unique case (state_q)
         StIdle: begin
            bit_d = 3'd0;
            if (v_i) begin
               shift_d = {m_i, d_i};
               if (m_i == 8'd0) begin
                  ill_d      = 1'b1;
                  err_code_d = 2'd1;
               end else begin
                  err_code_d = 2'd0;
                  state_d    = StLoadDCmd;
               end
            end
         end
         StLoadDCmd: begin
            prog_en_o   = 1'b1;
            prog_data_o = (bit_q == 3'd0);
            if (bit_q == 3'd1) begin
               bit_d   = 3'd0;
               state_d = StLoadDData;
            end
         end
         StLoadDData: begin
            prog_en_o   = 1'b1;
            prog_data_o = shift_q[0];
            shift_d     = shift_q >> 1;
            if (bit_q == 3'd7) state_d = StGap1;
         end
         StGap1: begin
            bit_d   = 3'd0;
            state_d = StLoadMCmd;
         end
         StLoadMCmd: begin
            prog_en_o   = 1'b1;
            prog_data_o = 1'b1;
            if (bit_q == 3'd1) begin
               bit_d   = 3'd0;
               state_d = StLoadMData;
            end
         end
         StLoadMData: begin
            // D has been shifted out, so M now sits in the low byte.
            prog_en_o   = 1'b1;
            prog_data_o = shift_q[0];
            shift_d     = shift_q >> 1;
            if (bit_q == 3'd7) state_d = StGap2;
         end
         StGap2: state_d = StGo;
         StGo: begin
            prog_en_o = 1'b1;
            state_d   = StWaitDone;
         end
         StWaitDone: begin
            cnt_d      = cnt_q + CntW'(1);
            seen_low_d = seen_low_q | ~prog_done_i;
            // A PROGDONE that was already high is stale until it has been seen low.
            if (seen_low_q && prog_done_i) begin
               cnt_d   = '0;
               state_d = StWaitLock;
            end else if (cnt_q == CntLast) begin
               err_now    = 1'b1;
               err_code_d = 2'd2;
               state_d    = StIdle;
            end
         end
         StWaitLock: begin
            cnt_d = cnt_q + CntW'(1);
            if (lock_s) begin
               done_o  = 1'b1;
               state_d = StIdle;
            end else if (cnt_q == CntLast) begin
               err_now    = 1'b1;
               err_code_d = 2'd3;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
